// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode seven-segment driver: shadow-latched digits, prescaled scan,
// one dark guard cycle per slot, registered active-low pins. Optional: LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
    parameter int DIGITS  = 4,
    parameter int CLK_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank,
    output logic [6:0]            seven,
    output logic                  dp,
    output logic [DIGITS-1:0]     anode,
    output logic                  frame_start
);
    localparam int PRE_W = $clog2(CLK_DIV);
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [PRE_W-1:0]    prescaler_q, prescaler_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] sh_value_q, sh_value_d;
    logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [DIGITS-1:0]   sh_blank_q, sh_blank_d;
    logic [6:0]          seven_q, seven_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   anode_q, anode_d;
    logic                frame_start_q, frame_start_d;
    logic                tick;
    logic [3:0]          cur_nib;
    logic [DIGITS-1:0]   lz_mask;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'h0:    decode = 7'b0000001;
            4'h1:    decode = 7'b1001111;
            4'h2:    decode = 7'b0010010;
            4'h3:    decode = 7'b0000110;
            4'h4:    decode = 7'b1001100;
            4'h5:    decode = 7'b0100100;
            4'h6:    decode = 7'b0100000;
            4'h7:    decode = 7'b0001111;
            4'h8:    decode = 7'b0000000;
            4'h9:    decode = 7'b0000100;
            4'hA:    decode = 7'b0001000;
            4'hB:    decode = 7'b1100000;
            4'hC:    decode = 7'b0110001;
            4'hD:    decode = 7'b1000010;
            4'hE:    decode = 7'b0110000;
            default: decode = 7'b0111000;
        endcase
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; a digit is suppressed while everything above it is zero.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        lz_mask    = '0;
        for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero & (sh_value_q[4*i +: 4] == 4'h0);
            lz_mask[i] = upper_zero;
        end
    end
`else
    assign lz_mask = '0;
`endif

    assign tick    = (prescaler_q == PRE_LAST);
    assign cur_nib = sh_value_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        prescaler_d   = tick ? '0 : prescaler_q + PRE_W'(1);
        idx_d         = idx_q;
        frame_start_d = 1'b0;
        if (tick) begin
            idx_d         = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            frame_start_d = (idx_q == IDX_LAST);
        end

        sh_value_d = sh_value_q;
        sh_dp_d    = sh_dp_q;
        sh_blank_d = sh_blank_q;
        if (load) begin
            sh_value_d = value;
            sh_dp_d    = dp_in;
            sh_blank_d = blank;
        end

        // Guard cycle: everything dark while the index is about to change.
        anode_d = '1;
        seven_d = '1;
        dp_d    = 1'b1;
        if (!tick) begin
            anode_d = ~(DIGITS'(1) << idx_q);
            seven_d = (sh_blank_q[idx_q] || lz_mask[idx_q]) ? 7'b1111111 : decode(cur_nib);
            dp_d    = sh_blank_q[idx_q] ? 1'b1 : ~sh_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler_q   <= '0;
            idx_q         <= '0;
            sh_value_q    <= '0;
            sh_dp_q       <= '0;
            sh_blank_q    <= '0;
            seven_q       <= '1;
            dp_q          <= 1'b1;
            anode_q       <= '1;
            frame_start_q <= 1'b0;
        end else begin
            prescaler_q   <= prescaler_d;
            idx_q         <= idx_d;
            sh_value_q    <= sh_value_d;
            sh_dp_q       <= sh_dp_d;
            sh_blank_q    <= sh_blank_d;
            seven_q       <= seven_d;
            dp_q          <= dp_d;
            anode_q       <= anode_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seven       = seven_q;
    assign dp          = dp_q;
    assign anode       = anode_q;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (DIGITS=4, CLK_DIV=4): stimulus queues per-cycle
// expected pin states, a negedge monitor pops and compares them.
module tb_seg7_scan_driver;
    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    logic [6:0]  seven;
    logic        dp;
    logic [3:0]  anode;
    logic        frame_start;

    seg7_scan_driver #(.DIGITS(4), .CLK_DIV(4)) dut (
        .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
        .blank(blank), .seven(seven), .dp(dp), .anode(anode), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] DEC [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef struct {
        int         cyc;
        logic [3:0] anode;
        logic [6:0] seven;
        logic       dp;
        logic       fs;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   base = 3;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc = cyc + 1;

    // Expected pins for the cycle following posedge c; base is the last reset edge.
    function automatic exp_t calc(int c, logic [15:0] v, logic [3:0] dpm, logic [3:0] blk, string tag);
        exp_t e;
        int m, d;
        logic [3:0] nib;
        logic lz;
        m = c - base;
        e.cyc = c;
        e.tag = tag;
        if (m % 4 == 0) begin
            e.anode = 4'b1111;
            e.seven = 7'b1111111;
            e.dp    = 1'b1;
            e.fs    = (m % 16 == 0);
        end else begin
            d   = ((m - 1) / 4) % 4;
            nib = v[4*d +: 4];
            lz  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            lz  = (d > 0) && ((v >> (4*d)) == 16'h0000);
`endif
            e.anode = ~(4'b0001 << d);
            e.seven = (blk[d] || lz) ? 7'b1111111 : DEC[nib];
            e.dp    = blk[d] ? 1'b1 : ~dpm[d];
            e.fs    = 1'b0;
        end
        return e;
    endfunction

    task automatic push_dark(input int c, input string tag);
        exp_t e;
        e.cyc = c; e.anode = 4'b1111; e.seven = 7'b1111111; e.dp = 1'b1; e.fs = 1'b0; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic push_range(input int c0, input int c1, input logic [15:0] v,
                              input logic [3:0] dpm, input logic [3:0] blk, input string tag);
        for (int c = c0; c <= c1; c++) exp_q.push_back(calc(c, v, dpm, blk, tag));
    endtask

    task automatic at_cycle(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Load lands on the tick edge that ends the previous frame; new data shows from cycle s.
    task automatic load_frame(input int s, input logic [15:0] v, input logic [3:0] dpm,
                              input logic [3:0] blk, input string tag);
        push_range(s, s + 15, v, dpm, blk, tag);
        at_cycle(s - 2);
        load = 1'b1; value = v; dp_in = dpm; blank = blk;
        at_cycle(s - 1);
        load = 1'b0;
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            n_cmp++;
            if (mon_e.cyc != cyc || anode !== mon_e.anode || seven !== mon_e.seven ||
                dp !== mon_e.dp || frame_start !== mon_e.fs) begin
                n_bad++;
                $display("FAIL %s cyc=%0d (exp for %0d): got anode=%b seven=%b dp=%b fs=%b, expected anode=%b seven=%b dp=%b fs=%b",
                         mon_e.tag, cyc, mon_e.cyc, anode, seven, dp, frame_start,
                         mon_e.anode, mon_e.seven, mon_e.dp, mon_e.fs);
            end
        end
    end

    initial begin
        int s;
        logic [3:0] n;
        reset = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank = '0;

        for (int c = 1; c <= 3; c++) push_dark(c, "reset");
        push_range(4, 5, 16'h0000, 4'b0000, 4'b0000, "first_zero");
        push_range(6, 35, 16'h1234, 4'b0000, 4'b0000, "scan_1234");
        at_cycle(3);
        reset = 1'b0;
        at_cycle(4);
        load = 1'b1; value = 16'h1234;
        at_cycle(5);
        load = 1'b0;

        for (int f = 2; f < 18; f++) begin
            n = 4'(f - 2);
            load_frame(4 + 16*f, {4{n}}, n, 4'b0000, "decode_sweep");
        end
        load_frame(4 + 16*18, 16'hABCD, 4'b0100, 4'b0001, "masks_tick_load");

        s = 4 + 16*19;
        push_range(s, s + 8, 16'h5678, 4'b0000, 4'b0000, "pre_reset");
        push_dark(s + 9, "mid_reset");
        base = s + 9;
        push_range(s + 10, base + 16, 16'h0000, 4'b0000, 4'b0000, "post_reset");
        at_cycle(s - 2);
        load = 1'b1; value = 16'h5678; dp_in = 4'b0000; blank = 4'b0000;
        at_cycle(s - 1);
        load = 1'b0;
        at_cycle(s + 8);
        reset = 1'b1; load = 1'b1; value = 16'hFFFF; dp_in = 4'b1111;
        at_cycle(s + 9);
        reset = 1'b0; load = 1'b0;

        load_frame(base + 17, 16'h0050, 4'b0000, 4'b0000, "lzb_0050");
        load_frame(base + 33, 16'h0000, 4'b1000, 4'b0000, "lzb_0000");

        for (int k = 0; k < 64 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL timeout: cyc=%0d, required completion", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end
endmodule
